div_ctrl: RTL and testbench

- EX-stage sequencer for the shared multi-cycle divider (div).
- Accepts a DIV/DIVU request from EX and latches the operands.
- Drives the divider's start/annul handshake and stalls the pipeline while the divider runs.
- Returns the quotient/remainder as a one-shot HI/LO write. A pipeline flush cancels the operation.

---
 rtl/div_ctrl_pkg.sv | 21 ++
 rtl/div_ctrl.sv | 101 ++++++++++
 tb/tb_div_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared defines for the EX-stage divider sequencer: FSM encodings and
// handshake/reset constants used by div_ctrl and the divider beside it.
package div_ctrl_pkg;

    localparam int DC_DW = 32;

    typedef enum logic [1:0] {
        DC_IDLE = 2'd0,
        DC_BUSY = 2'd1,
        DC_DONE = 2'd2
    } dc_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic RstEnable         = 1'b1;

    localparam logic [DC_DW-1:0] ZeroWord = '0;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the shared multi-cycle divider: latches operands,
// drives start/annul, stalls EX and returns a one-shot HI/LO write.
// Optional: DIV_ZERO_BYPASS_EN skips the divider for a zero divisor.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW = DC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_req_i,
    input  logic          signed_i,
    input  logic [DW-1:0] op1_i,
    input  logic [DW-1:0] op2_i,
    input  logic          flush_i,
    input  logic          stall_i,
    input  logic          div_ready_i,
    input  logic [2*DW-1:0] div_result_i,
    output logic          div_start_o,
    output logic          div_annul_o,
    output logic          div_signed_o,
    output logic [DW-1:0] div_op1_o,
    output logic [DW-1:0] div_op2_o,
    output logic          stallreq_o,
    output logic          whilo_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    dc_state_e state;

    // Operands only change on acceptance in IDLE, so they stay stable
    // through BUSY and DONE while the divider re-reads them for sign fix-up.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state        <= DC_IDLE;
            div_signed_o <= 1'b0;
            div_op1_o    <= DW'(ZeroWord);
            div_op2_o    <= DW'(ZeroWord);
            hi_o         <= DW'(ZeroWord);
            lo_o         <= DW'(ZeroWord);
        end else begin
            case (state)
                DC_IDLE: begin
                    if (div_req_i && !flush_i) begin
                        div_signed_o <= signed_i;
                        div_op1_o    <= op1_i;
                        div_op2_o    <= op2_i;
`ifdef DIV_ZERO_BYPASS_EN
                        if (op2_i == DW'(ZeroWord)) begin
                            hi_o  <= DW'(ZeroWord);
                            lo_o  <= DW'(ZeroWord);
                            state <= DC_DONE;
                        end else begin
                            state <= DC_BUSY;
                        end
`else
                        state <= DC_BUSY;
`endif
                    end
                end
                DC_BUSY: begin
                    if (flush_i) begin
                        state <= DC_IDLE;
                    end else if (div_ready_i != DivResultNotReady) begin
                        hi_o  <= div_result_i[2*DW-1:DW];
                        lo_o  <= div_result_i[DW-1:0];
                        state <= DC_DONE;
                    end
                end
                DC_DONE: begin
                    if (flush_i || !stall_i)
                        state <= DC_IDLE;
                end
                default: state <= DC_IDLE;
            endcase
        end
    end

    // Start drops in DONE and the following IDLE cycle, so the divider always
    // sees DivStop between two operations.
    always_comb begin
        div_start_o = DivStop;
        div_annul_o = 1'b0;
        stallreq_o  = 1'b0;
        whilo_o     = 1'b0;
        if (rst != RstEnable) begin
            case (state)
                DC_IDLE: stallreq_o = div_req_i & ~flush_i;
                DC_BUSY: begin
                    div_start_o = DivStart;
                    if (flush_i) div_annul_o = 1'b1;
                    else         stallreq_o  = 1'b1;
                end
                DC_DONE: whilo_o = ~flush_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural multi-cycle divider beside it.
// Build with +define+DIV_ZERO_BYPASS_EN to exercise the zero-divisor bypass.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int DW  = 32;
    localparam int LAT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          div_req_i = 1'b0;
    logic          signed_i = 1'b0;
    logic [DW-1:0] op1_i = '0;
    logic [DW-1:0] op2_i = '0;
    logic          flush_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          div_ready_i;
    logic [2*DW-1:0] div_result_i;
    logic          div_start_o, div_annul_o, div_signed_o;
    logic [DW-1:0] div_op1_o, div_op2_o;
    logic          stallreq_o, whilo_o;
    logic [DW-1:0] hi_o, lo_o;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0, whilo_cnt = 0, annul_cnt = 0;

    always #5 clk = ~clk;

    div_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .div_req_i(div_req_i), .signed_i(signed_i),
        .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .stall_i(stall_i),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    // Behavioural divider: result valid LAT cycles after start, cleared on stop/annul.
    logic [7:0]    dv_cnt;
    logic [DW-1:0] dv_q, dv_r;
    always_ff @(posedge clk) begin
        if (rst || !div_start_o || div_annul_o) dv_cnt <= '0;
        else if (dv_cnt < 8'(LAT))              dv_cnt <= dv_cnt + 8'd1;
    end
    assign div_ready_i = (dv_cnt == 8'(LAT));

    always_comb begin
        dv_q = '0;
        dv_r = '0;
        if (div_op2_o != '0) begin
            if (div_signed_o) begin
                dv_q = $signed(div_op1_o) / $signed(div_op2_o);
                dv_r = $signed(div_op1_o) % $signed(div_op2_o);
            end else begin
                dv_q = div_op1_o / div_op2_o;
                dv_r = div_op1_o % div_op2_o;
            end
        end
        div_result_i = {dv_r, dv_q};
    end

    always @(negedge clk) begin
        #2;
        if (div_start_o) start_cnt++;
        if (whilo_o)     whilo_cnt++;
        if (div_annul_o) annul_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one divide at the next negedge, follow it to DONE and hold DONE
    // for stall_cyc extra cycles. Returns with DONE as the current cycle.
    task automatic run_div(input string tag, input logic sg, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] elo,
                           input logic [DW-1:0] ehi, input int stall_cyc,
                           output int busy_cyc, output int starts);
        int  s0, w0;
        bit  stall_ok, held;
        @(negedge clk);
        s0 = start_cnt;
        w0 = whilo_cnt;
        div_req_i = 1'b1; signed_i = sg; op1_i = a; op2_i = b;
        #1;
        chk({tag, ".req_state"}, 64'(dut.state), 64'(DC_IDLE));
        chk({tag, ".req_start"}, 64'(div_start_o), 64'd0);
        chk({tag, ".req_stall"}, 64'(stallreq_o), 64'd1);
        @(negedge clk);
        div_req_i = 1'b0;
        #1;
        chk({tag, ".op1"}, 64'(div_op1_o), 64'(a));
        chk({tag, ".op2"}, 64'(div_op2_o), 64'(b));
        chk({tag, ".sgn"}, 64'(div_signed_o), 64'(sg));
        busy_cyc = 0;
        stall_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (whilo_o) break;
            if (!stallreq_o) stall_ok = 1'b0;
            busy_cyc++;
            @(negedge clk);
            #1;
        end
        chk({tag, ".whilo"}, 64'(whilo_o), 64'd1);
        chk({tag, ".busy_stall"}, 64'(stall_ok), 64'd1);
        chk({tag, ".lo"}, 64'(lo_o), 64'(elo));
        chk({tag, ".hi"}, 64'(hi_o), 64'(ehi));
        chk({tag, ".done_start"}, 64'(div_start_o), 64'd0);
        chk({tag, ".done_stall"}, 64'(stallreq_o), 64'd0);
        if (stall_cyc > 0) begin
            stall_i = 1'b1;
            held = 1'b1;
            for (int k = 0; k < stall_cyc; k++) begin
                @(negedge clk);
                if (k == stall_cyc - 1) stall_i = 1'b0;
                #1;
                if (!whilo_o || lo_o !== elo || hi_o !== ehi) held = 1'b0;
            end
            chk({tag, ".stall_hold"}, 64'(held), 64'd1);
        end
        #2;
        chk({tag, ".whilo_cycles"}, 64'(whilo_cnt - w0), 64'(1 + stall_cyc));
        starts = start_cnt - s0;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        #1;
        chk({tag, ".idle_state"}, 64'(dut.state), 64'(DC_IDLE));
        chk({tag, ".idle_whilo"}, 64'(whilo_o), 64'd0);
        chk({tag, ".idle_start"}, 64'(div_start_o), 64'd0);
    endtask

    initial begin
        int bc, st, a0, w0;

        // Reset state
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst.state", 64'(dut.state), 64'(DC_IDLE));
        chk("rst.outs", {div_start_o, div_annul_o, stallreq_o, whilo_o, div_signed_o},
            64'd0);
        chk("rst.data", {hi_o, lo_o}, 64'd0);
        rst = 1'b0;

        // Signed 100 / 7
        run_div("s100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 0, bc, st);
        chk("s100_7.busy_cycles", 64'(bc), 64'(LAT + 1));
        idle_chk("s100_7");

        // -7 / 2 signed and unsigned
        run_div("sneg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, bc, st);
        idle_chk("sneg7_2");
        run_div("uneg7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 0, bc, st);
        idle_chk("uneg7_2");

        // Flush 10 cycles into BUSY, then 9 / 3
        @(negedge clk);
        w0 = whilo_cnt;
        a0 = annul_cnt;
        div_req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd100; op2_i = 32'd7;
        @(negedge clk);
        div_req_i = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush.state", 64'(dut.state), 64'(DC_BUSY));
        chk("flush.annul", 64'(div_annul_o), 64'd1);
        chk("flush.stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush.after_state", 64'(dut.state), 64'(DC_IDLE));
        chk("flush.annul_cycles", 64'(annul_cnt - a0), 64'd1);
        chk("flush.no_whilo", 64'(whilo_cnt - w0), 64'd0);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, bc, st);
        idle_chk("u9_3");

        // Back-to-back: second request lands in the IDLE cycle right after DONE
        run_div("b2b_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 0, bc, st);
        run_div("b2b_50_7", 1'b0, 32'd50, 32'd7, 32'd7, 32'd1, 0, bc, st);
        idle_chk("b2b_50_7");

        // DONE held by a 3-cycle downstream stall
        run_div("stall3", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 3, bc, st);
        idle_chk("stall3");

        // Reset in the middle of BUSY
        @(negedge clk);
        div_req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd100; op2_i = 32'd7;
        @(negedge clk);
        div_req_i = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstbusy.forced", {div_start_o, div_annul_o, stallreq_o, whilo_o}, 64'd0);
        @(negedge clk);
        #1;
        chk("rstbusy.state", 64'(dut.state), 64'(DC_IDLE));
        chk("rstbusy.ops", {div_signed_o, div_op1_o}, 64'd0);
        chk("rstbusy.op2", 64'(div_op2_o), 64'd0);
        chk("rstbusy.hilo", {hi_o, lo_o}, 64'd0);
        rst = 1'b0;

        // 5 / 0
`ifdef DIV_ZERO_BYPASS_EN
        run_div("z5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 0, bc, st);
        chk("z5_0.busy_cycles", 64'(bc), 64'd0);
        chk("z5_0.no_start", 64'(st), 64'd0);
`else
        run_div("z5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 0, bc, st);
        chk("z5_0.busy_cycles", 64'(bc), 64'(LAT + 1));
`endif
        idle_chk("z5_0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
